// File: rtl/serial_subtractor.sv
// Bit-serial subtractor d = a - b - b_in, LSB first, one bit per clock with a single borrow flop.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             b_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  // state | meaning
  // IDLE  | waiting for start; operands captured on accept
  // RUN   | one difference bit per cycle, LSB first
  // DONE  | result valid, done pulses for this cycle only
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-2:0] res;
  logic             borrow;
  logic [CW-1:0]    cnt;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb;
  logic             b_msb;
`endif

  logic             x;
  logic             diff_bit;
  logic             borrow_nxt;
  logic [WIDTH-1:0] res_nxt;

  always_comb begin
    x          = sa[0] ^ sb[0];
    diff_bit   = x ^ borrow;
    borrow_nxt = (~sa[0] & sb[0]) | (~x & borrow);
    // new bit enters at the MSB; after WIDTH shifts res_nxt is the full difference
    res_nxt    = {diff_bit, res};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      d      <= '0;
      b_out  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa     <= a;
            sb     <= b;
            borrow <= b_in;
            res    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
`ifdef SERIAL_SUB_OVF_EN
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          borrow <= borrow_nxt;
          res    <= res_nxt[WIDTH-1:1];
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            d     <= res_nxt;
            b_out <= borrow_nxt;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= (a_msb != b_msb) & (diff_bit != a_msb);
`endif
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: driver pushes arithmetic expectations, monitor pops on done.
// Define SERIAL_SUB_OVF_EN to also check the ovf port.
module tb_serial_subtractor;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         b_out;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .b_out (b_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int           s0;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  int   ready_edge = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Reference: plain wide subtraction; borrow is the bit above the result.
  function automatic exp_t model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                 input logic bi, input int s0);
    exp_t     e;
    logic [W:0] full;
    full = {1'b0, aa} - {1'b0, bb} - {{W{1'b0}}, bi};
    e.s0 = s0;
    e.d  = full[W-1:0];
    e.bo = full[W];
    e.ov = (aa[W-1] != bb[W-1]) && (full[W-1] != aa[W-1]);
    return e;
  endfunction

  task automatic drive(input logic s, input logic [W-1:0] aa, input logic [W-1:0] bb, input logic bi);
    @(negedge clk);
    rst   = 1'b0;
    start = s;
    a     = aa;
    b     = bb;
    b_in  = bi;
    if (s && (edge_cnt + 1 >= ready_edge)) begin
      q.push_back(model(aa, bb, bi, edge_cnt + 1));
      ready_edge = edge_cnt + 1 + W + 2;
    end
  endtask

  task automatic do_op(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic bi);
    int n;
    n = 0;
    while ((edge_cnt + 1 < ready_edge) && (n < 100)) begin
      drive(1'b0, aa, bb, bi);
      n++;
    end
    drive(1'b1, aa, bb, bi);
    drive(1'b0, W'($urandom), W'($urandom), 1'($urandom));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    ready_edge = edge_cnt + 2;
  endtask

  // Monitor
  logic [W-1:0] hd = '0;
  logic         hbo = 1'b0;
  logic         hov = 1'b0;
  always begin
    exp_t e;
    logic exp_busy, exp_done;
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      hd = '0; hbo = 1'b0; hov = 1'b0;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_d", 32'(d), 32'd0);
      check("rst_b_out", 32'(b_out), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
      check("rst_ovf", 32'(ovf), 32'd0);
`endif
    end else begin
      exp_busy = (q.size() > 0) && (edge_cnt >= q[0].s0) && (edge_cnt < q[0].s0 + W);
      exp_done = (q.size() > 0) && (edge_cnt == q[0].s0 + W);
      check("busy", 32'(busy), 32'(exp_busy));
      check("done", 32'(done), 32'(exp_done));
      if (exp_done) begin
        e = q.pop_front();
        check("d", 32'(d), 32'(e.d));
        check("b_out", 32'(b_out), 32'(e.bo));
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", 32'(ovf), 32'(e.ov));
`endif
        hd = e.d; hbo = e.bo; hov = e.ov;
      end else begin
        check("d_hold", 32'(d), 32'(hd));
        check("b_out_hold", 32'(b_out), 32'(hbo));
`ifdef SERIAL_SUB_OVF_EN
        check("ovf_hold", 32'(ovf), 32'(hov));
`endif
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
    repeat (2) @(negedge clk);
    ready_edge = edge_cnt + 1;

    do_op(4'b1011, 4'b0110, 1'b0);
    do_op(4'b0011, 4'b0101, 1'b0);
    do_op(4'b0000, 4'b0000, 1'b1);
    do_op(4'b1111, 4'b1111, 1'b0);
    do_op(4'b0111, 4'b1000, 1'b0);
    do_op(4'b0101, 4'b0011, 1'b0);

    // start held high with operands changing every cycle
    for (int i = 0; i < 3 * (W + 2) + 2; i++)
      drive(1'b1, W'($urandom), W'($urandom), 1'($urandom));
    drive(1'b0, '0, '0, 1'b0);

    // abort after two bit cycles, then a fresh operation
    do_op(4'b1001, 4'b0010, 1'b1);
    drive(1'b0, '0, '0, 1'b0);
    do_reset();
    do_op(4'b1100, 4'b0101, 1'b1);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: do_op(W'($urandom), W'($urandom), 1'($urandom));
        1: for (int j = 0; j < int'($urandom_range(1, 12)); j++)
             drive(1'b1, W'($urandom), W'($urandom), 1'($urandom));
        default: for (int j = 0; j < int'($urandom_range(0, 3)); j++)
             drive(1'b0, W'($urandom), W'($urandom), 1'($urandom));
      endcase
    end
    drive(1'b0, '0, '0, 1'b0);

    n = 0;
    while ((q.size() != 0) && (n < 100)) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
